col_output_packer: RTL and testbench

//  Parametrised column-output controller for the systolic array. Captures one row of
//  per-column results (data + valid mask), packs it into OUT_W-bit words of LANES column

---
 rtl/col_out_pkg.sv | 10 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/col_output_packer.sv | 117 +++++++++++
 tb/tb_col_output_packer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/col_out_pkg.sv
// Shared types and helpers for the array's output-side blocks.
package col_out_pkg;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO; the head word reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/col_output_packer.sv
// Captures a row of column results, packs valid groups into lane words and queues them.
module col_output_packer
  import col_out_pkg::*;
#(
  parameter int N_COLS     = 8,
  parameter int DATA_W     = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_COLS-1:0][DATA_W-1:0]  in_r,
  input  logic [N_COLS-1:0]              in_v,
  output logic                           in_ready,
  output logic [OUT_W-1:0]               out_r,
  output logic [OUT_W/DATA_W-1:0]        out_mask,
  output logic                           out_last,
  output logic                           rvalid,
  input  logic                           rread
);

  localparam int LANES   = OUT_W / DATA_W;
  localparam int NGROUPS = ceil_div(N_COLS, LANES);
  localparam int PAD     = NGROUPS * LANES;
  localparam int GW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  state_t                        state;
  logic [PAD-1:0][DATA_W-1:0]    row_q;
  logic [PAD-1:0]                mask_q;
  logic [GW-1:0]                 grp;
  logic [PAD-1:0][DATA_W-1:0]    r_pad;
  logic [PAD-1:0]                v_pad;
  logic [PAD-1:0][DATA_W-1:0]    r_cap;
  logic [LANES-1:0]              grp_mask;
  logic [OUT_W-1:0]              grp_data;
  logic                          grp_last;
  logic                          push;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [OUT_W+LANES:0]          fifo_dout;

  // Widen the row to whole groups; pad and invalid columns capture as zero.
  always_comb begin
    r_pad = '0;
    v_pad = '0;
    r_pad[N_COLS-1:0] = in_r;
    v_pad[N_COLS-1:0] = in_v;
    for (int i = 0; i < PAD; i++) begin
      r_cap[i] = v_pad[i] ? r_pad[i] : '0;
    end
  end

  // Select the current group and see whether any later group still holds valid columns.
  always_comb begin
    grp_mask = '0;
    grp_data = '0;
    grp_last = 1'b1;
    for (int j = 0; j < NGROUPS; j++) begin
      if (GW'(j) == grp) begin
        grp_mask = mask_q[j*LANES +: LANES];
        grp_data = row_q[j*LANES +: LANES];
      end else if (GW'(j) > grp && |mask_q[j*LANES +: LANES]) begin
        grp_last = 1'b0;
      end
    end
  end

  assign push = (state == DRAIN) && (|grp_mask) && !fifo_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grp    <= '0;
      row_q  <= '0;
      mask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_v) begin
            row_q  <= r_cap;
            mask_q <= v_pad;
            grp    <= '0;
            state  <= DRAIN;
          end
        end
        DRAIN: begin
          if (push) begin
            if (grp_last) state <= IDLE;
            else          grp   <= grp + GW'(1);
          end else if (!(|grp_mask)) begin
            grp <= grp + GW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W + LANES + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({grp_data, grp_mask, grp_last}),
    .pop   (rread),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {out_r, out_mask, out_last} = fifo_dout;
  assign rvalid   = !fifo_empty;
  assign in_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_col_output_packer.sv
// Directed bench: default 8-column packer plus a 6-column instance for pad-lane handling.
module tb_col_output_packer;

  logic             clk = 1'b0;
  logic             rst;

  logic [7:0][7:0]  a_in_r;
  logic [7:0]       a_in_v;
  logic             a_in_ready;
  logic [31:0]      a_out_r;
  logic [3:0]       a_out_mask;
  logic             a_out_last;
  logic             a_rvalid;
  logic             a_rread;

  logic [5:0][7:0]  b_in_r;
  logic [5:0]       b_in_v;
  logic             b_in_ready;
  logic [31:0]      b_out_r;
  logic [3:0]       b_out_mask;
  logic             b_out_last;
  logic             b_rvalid;
  logic             b_rread;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  col_output_packer u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .in_r     (a_in_r),
    .in_v     (a_in_v),
    .in_ready (a_in_ready),
    .out_r    (a_out_r),
    .out_mask (a_out_mask),
    .out_last (a_out_last),
    .rvalid   (a_rvalid),
    .rread    (a_rread)
  );

  col_output_packer #(.N_COLS(6)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .in_r     (b_in_r),
    .in_v     (b_in_v),
    .in_ready (b_in_ready),
    .out_r    (b_out_r),
    .out_mask (b_out_mask),
    .out_last (b_out_last),
    .rvalid   (b_rvalid),
    .rread    (b_rread)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present one row for a single cycle.
  task automatic applyStimulus(input logic [7:0] v);
    int n = 0;
    while (!a_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!a_in_ready) checkOutput("accept_timeout", 64'(a_in_ready), 64'h1);
    a_in_v = v;
    tick();
    a_in_v = '0;
  endtask

  // Wait (bounded) for a head word on DUT A, check it, then let rread pop it.
  task automatic expectWord(input string tag, input logic [31:0] data,
                            input logic [3:0] mask, input logic last);
    int n = 0;
    while (!a_rvalid && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_rvalid"}, 64'(a_rvalid), 64'h1);
    checkOutput({tag, "_data"},   64'(a_out_r),    64'(data));
    checkOutput({tag, "_mask"},   64'(a_out_mask), 64'(mask));
    checkOutput({tag, "_last"},   64'(a_out_last), 64'(last));
    tick();
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    a_in_v  = '0;
    a_rread = 1'b0;
    b_in_v  = '0;
    b_rread = 1'b0;
    for (int i = 0; i < 8; i++) a_in_r[i] = 8'(i + 1);
    for (int i = 0; i < 6; i++) b_in_r[i] = 8'(i + 1);

    repeat (2) tick();
    checkOutput("rst_in_ready", 64'(a_in_ready), 64'h0);
    checkOutput("rst_rvalid",   64'(a_rvalid),   64'h0);
    checkOutput("rst_out_r",    64'(a_out_r),    64'h0);
    checkOutput("rst_out_mask", 64'(a_out_mask), 64'h0);
    checkOutput("rst_out_last", 64'(a_out_last), 64'h0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", 64'(a_in_ready), 64'h1);

    // Full row: two words, rvalid two cycles after the accept.
    a_rread = 1'b1;
    applyStimulus(8'hFF);
    checkOutput("t1_rvalid_c1", 64'(a_rvalid), 64'h0);
    tick();
    checkOutput("t1_rvalid_c2", 64'(a_rvalid),   64'h1);
    checkOutput("t1_w0_data",   64'(a_out_r),    64'h04030201);
    checkOutput("t1_w0_mask",   64'(a_out_mask), 64'hF);
    checkOutput("t1_w0_last",   64'(a_out_last), 64'h0);
    tick();
    checkOutput("t1_w1_data",   64'(a_out_r),    64'h08070605);
    checkOutput("t1_w1_mask",   64'(a_out_mask), 64'hF);
    checkOutput("t1_w1_last",   64'(a_out_last), 64'h1);
    checkOutput("t1_in_ready",  64'(a_in_ready), 64'h1);
    tick();
    checkOutput("t1_empty",     64'(a_rvalid),   64'h0);

    // Only column 5 valid: group 0 skipped.
    applyStimulus(8'h20);
    expectWord("t2", 32'h00000600, 4'b0010, 1'b1);
    checkOutput("t2_empty", 64'(a_rvalid), 64'h0);

    // Only group 0 valid: back in IDLE when the word appears.
    applyStimulus(8'h03);
    n = 0;
    while (!a_rvalid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t3_in_ready", 64'(a_in_ready), 64'h1);
    expectWord("t3", 32'h00000201, 4'b0011, 1'b1);
    checkOutput("t3_empty", 64'(a_rvalid), 64'h0);

    // Backpressure: three rows with no reads, third row stalls.
    a_rread = 1'b0;
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    repeat (4) tick();
    checkOutput("t4_stall_in_ready", 64'(a_in_ready), 64'h0);
    checkOutput("t4_stall_rvalid",   64'(a_rvalid),   64'h1);
    checkOutput("t4_stall_head",     64'(a_out_r),    64'h04030201);
    a_rread = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expectWord($sformatf("t4_r%0d_w0", k), 32'h04030201, 4'hF, 1'b0);
      expectWord($sformatf("t4_r%0d_w1", k), 32'h08070605, 4'hF, 1'b1);
    end
    checkOutput("t4_empty",    64'(a_rvalid),   64'h0);
    checkOutput("t4_in_ready", 64'(a_in_ready), 64'h1);

    // Reset while draining with two words queued.
    a_rread = 1'b0;
    applyStimulus(8'hFF);
    applyStimulus(8'hFF);
    checkOutput("t5_pre_rvalid",   64'(a_rvalid),   64'h1);
    checkOutput("t5_pre_in_ready", 64'(a_in_ready), 64'h0);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_rvalid",   64'(a_rvalid),   64'h0);
    checkOutput("t5_rst_in_ready", 64'(a_in_ready), 64'h0);
    rst = 1'b0;
    tick();
    checkOutput("t5_in_ready",     64'(a_in_ready), 64'h1);
    a_rread = 1'b1;
    repeat (5) tick();
    checkOutput("t5_no_stale",     64'(a_rvalid),   64'h0);
    applyStimulus(8'h03);
    expectWord("t5_fresh", 32'h00000201, 4'b0011, 1'b1);

    // Six columns: second group carries two pad lanes.
    b_rread = 1'b1;
    checkOutput("t6_in_ready", 64'(b_in_ready), 64'h1);
    b_in_v = 6'h3F;
    tick();
    b_in_v = '0;
    n = 0;
    while (!b_rvalid && n < 50) begin
      tick();
      n++;
    end
    checkOutput("t6_w0_rvalid", 64'(b_rvalid),   64'h1);
    checkOutput("t6_w0_data",   64'(b_out_r),    64'h04030201);
    checkOutput("t6_w0_mask",   64'(b_out_mask), 64'hF);
    checkOutput("t6_w0_last",   64'(b_out_last), 64'h0);
    tick();
    checkOutput("t6_w1_rvalid", 64'(b_rvalid),   64'h1);
    checkOutput("t6_w1_data",   64'(b_out_r),    64'h00000605);
    checkOutput("t6_w1_mask",   64'(b_out_mask), 64'h3);
    checkOutput("t6_w1_last",   64'(b_out_last), 64'h1);
    tick();
    checkOutput("t6_empty",     64'(b_rvalid),   64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
